interrupt_ack_sequencer: RTL and testbench

INTERRUPT_ACK_SEQUENCER -- requirements
Module: interrupt_ack_sequencer

---
 rtl/pic_pkg.sv | 36 +++
 rtl/priority_encoder8.sv | 29 ++
 rtl/interrupt_ack_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_interrupt_ack_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg
//   Shared definitions for the interrupt acknowledge sequencer:
//     - pic_state_e : acknowledge sequence state encoding
//     - LEVEL_W     : width of an interrupt level index (IR0..IR7)
//     - VBASE_W     : width of the vector base (ICW2 T7..T3)
//     - above_mask  : mask of levels strictly higher in priority than the
//                     highest in-service level
// ---------------------------------------------------------------------------
package pic_pkg;

    localparam int LEVEL_W = 3;
    localparam int VBASE_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ACK1  = 3'd2,
        ST_WAIT2 = 3'd3,
        ST_ACK2  = 3'd4
    } pic_state_e;

    // IR0 is the highest priority, so "strictly higher than level n" means
    // every bit below n. With nothing in service every level is eligible.
    function automatic logic [7:0] above_mask(input logic [LEVEL_W-1:0] idx,
                                              input logic               valid);
        logic [7:0] m;
        if (valid) begin
            m = (8'h01 << idx) - 8'h01;
        end else begin
            m = 8'hFF;
        end
        return m;
    endfunction

endpackage

// File: rtl/priority_encoder8.sv
// ---------------------------------------------------------------------------
// priority_encoder8
//   Returns the index of the lowest set bit of an 8-bit vector, which is the
//   highest-priority level in the fixed IR0-first scheme.
//   Ports:
//     req_i   [7:0] input vector
//     idx_o   [2:0] index of the lowest set bit (0 when none set)
//     valid_o       at least one bit of req_i is set
// ---------------------------------------------------------------------------
module priority_encoder8
    import pic_pkg::*;
(
    input  logic [7:0]         req_i,
    output logic [LEVEL_W-1:0] idx_o,
    output logic               valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        // Scan from the top down so the lowest set bit is the last one written.
        for (int i = 7; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = LEVEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// ---------------------------------------------------------------------------
// interrupt_ack_sequencer
//   8259-style interrupt acknowledge sequencer. Picks the highest-priority
//   eligible request, raises INT, and walks the two-pulse INTA cycle: the
//   first pulse marks the level in service and clears its IRR bit, the
//   second pulse drives the vector {vectorBase, level} onto dataBuffer.
//
//   Parameter:
//     AEOI           1 = in-service bit cleared at the end of the 2nd pulse
//   Ports:
//     clk            system clock, rising edge
//     rst_n          asynchronous active-low reset
//     risedBits[7:0] unmasked pending requests (bit n = IRn)
//     vectorBase[4:0]upper vector bits
//     INTA_n         CPU acknowledge, active low, synchronous to clk
//     eoi            one-cycle non-specific end-of-interrupt strobe
//     INT            interrupt request to the CPU
//     dataBuffer[7:0]vector byte, zero whenever dataEnable is low
//     dataEnable     drive enable for dataBuffer
//     resetIRR[2:0]  level whose IRR bit must be cleared
//     resetIRRValid  one-cycle qualifier for resetIRR
//     ISR[7:0]       in-service register
//
//   Handshake: there is no valid/ready pair here; INTA_n is treated as a
//   level sampled every clock, and its edges are found by comparing against
//   the value registered on the previous clock. resetIRRValid is a one-cycle
//   pulse and resetIRR is only meaningful while it is high.
// ---------------------------------------------------------------------------
module interrupt_ack_sequencer
    import pic_pkg::*;
#(
    parameter logic AEOI = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         risedBits,
    input  logic [VBASE_W-1:0] vectorBase,
    input  logic               INTA_n,
    input  logic               eoi,
    output logic               INT,
    output logic [7:0]         dataBuffer,
    output logic               dataEnable,
    output logic [LEVEL_W-1:0] resetIRR,
    output logic               resetIRRValid,
    output logic [7:0]         ISR
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    pic_state_e         state_q;
    logic               inta_prev_q;
    logic [LEVEL_W-1:0] level_q;
    logic               spurious_q;
    logic [7:0]         isr_q;
    logic [7:0]         isr_d;
    logic               int_q;
    logic               data_en_q;
    logic [7:0]         data_q;
    logic [LEVEL_W-1:0] reset_irr_q;
    logic               reset_irr_valid_q;

    // -----------------------------------------------------------------------
    // Priority resolution
    // -----------------------------------------------------------------------
    logic [LEVEL_W-1:0] isr_idx;
    logic               isr_valid;
    logic [7:0]         eligible;
    logic [LEVEL_W-1:0] req_idx;
    logic               req_valid;

    // Highest set ISR bit: both the priority ceiling and the EOI target.
    priority_encoder8 u_isr_enc (
        .req_i   (isr_q),
        .idx_o   (isr_idx),
        .valid_o (isr_valid)
    );

    assign eligible = risedBits & above_mask(isr_idx, isr_valid);

    priority_encoder8 u_req_enc (
        .req_i   (eligible),
        .idx_o   (req_idx),
        .valid_o (req_valid)
    );

    // -----------------------------------------------------------------------
    // INTA edge detection
    // -----------------------------------------------------------------------
    logic inta_fall;
    logic inta_rise;

    assign inta_fall =  inta_prev_q & ~INTA_n;
    assign inta_rise = ~inta_prev_q &  INTA_n;

    // -----------------------------------------------------------------------
    // ISR next value
    //   The EOI target is chosen from the current ISR, so a level being set
    //   on the same edge is never the one an EOI clears.
    // -----------------------------------------------------------------------
    logic ack_take;
    logic aeoi_clear;

    assign ack_take   = (state_q == ST_REQ) && inta_fall && req_valid;
    assign aeoi_clear = AEOI && (state_q == ST_ACK2) && inta_rise && !spurious_q;

    always_comb begin
        isr_d = isr_q;
        if (eoi && isr_valid) begin
            isr_d[isr_idx] = 1'b0;
        end
        if (ack_take) begin
            isr_d[req_idx] = 1'b1;
        end
        if (aeoi_clear) begin
            isr_d[level_q] = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            inta_prev_q       <= 1'b1;
            level_q           <= '0;
            spurious_q        <= 1'b0;
            isr_q             <= '0;
            int_q             <= 1'b0;
            data_en_q         <= 1'b0;
            data_q            <= '0;
            reset_irr_q       <= '0;
            reset_irr_valid_q <= 1'b0;
        end else begin
            inta_prev_q       <= INTA_n;
            isr_q             <= isr_d;
            reset_irr_valid_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_q <= ST_REQ;
                        int_q   <= 1'b1;
                    end
                end

                ST_REQ: begin
                    if (inta_fall) begin
                        state_q <= ST_ACK1;
                        if (req_valid) begin
                            level_q           <= req_idx;
                            spurious_q        <= 1'b0;
                            reset_irr_q       <= req_idx;
                            reset_irr_valid_q <= 1'b1;
                        end else begin
                            // Request vanished before the acknowledge: the
                            // CPU still gets a full cycle, with IR7's vector.
                            level_q    <= LEVEL_W'(7);
                            spurious_q <= 1'b1;
                        end
                    end else if (!req_valid && INTA_n) begin
                        // Withdrawn before the CPU started acknowledging.
                        state_q <= ST_IDLE;
                        int_q   <= 1'b0;
                    end
                end

                ST_ACK1: begin
                    if (inta_rise) begin
                        state_q <= ST_WAIT2;
                    end
                end

                ST_WAIT2: begin
                    if (inta_fall) begin
                        // vectorBase is captured here and held for the pulse.
                        state_q   <= ST_ACK2;
                        data_en_q <= 1'b1;
                        data_q    <= {vectorBase, level_q};
                    end
                end

                ST_ACK2: begin
                    if (inta_rise) begin
                        state_q   <= ST_IDLE;
                        int_q     <= 1'b0;
                        data_en_q <= 1'b0;
                        data_q    <= '0;
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    int_q     <= 1'b0;
                    data_en_q <= 1'b0;
                    data_q    <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign INT           = int_q;
    assign dataBuffer    = data_q;
    assign dataEnable    = data_en_q;
    assign resetIRR      = reset_irr_q;
    assign resetIRRValid = reset_irr_valid_q;
    assign ISR           = isr_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// ---------------------------------------------------------------------------
// tb_interrupt_ack_sequencer
//   Directed bench for interrupt_ack_sequencer. Two instances share inputs:
//   one with AEOI=0 (main checks) and one with AEOI=1. Expected vectors are
//   queued when the second INTA pulse is driven and popped when dataEnable
//   is seen.
// ---------------------------------------------------------------------------
module tb_interrupt_ack_sequencer;

  // clock / reset
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // stimulus
  logic [7:0] risedBits;
  logic [4:0] vectorBase;
  logic       INTA_n;
  logic       eoi;

  // AEOI=0 instance outputs
  logic       irq;
  logic [7:0] dbuf;
  logic       den;
  logic [2:0] irr;
  logic       irr_valid;
  logic [7:0] isr;

  // AEOI=1 instance outputs
  logic       a_irq;
  logic [7:0] a_dbuf;
  logic       a_den;
  logic [2:0] a_irr;
  logic       a_irr_valid;
  logic [7:0] a_isr;

  interrupt_ack_sequencer #(.AEOI(1'b0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .risedBits     (risedBits),
    .vectorBase    (vectorBase),
    .INTA_n        (INTA_n),
    .eoi           (eoi),
    .INT           (irq),
    .dataBuffer    (dbuf),
    .dataEnable    (den),
    .resetIRR      (irr),
    .resetIRRValid (irr_valid),
    .ISR           (isr)
  );

  interrupt_ack_sequencer #(.AEOI(1'b1)) dut_aeoi (
    .clk           (clk),
    .rst_n         (rst_n),
    .risedBits     (risedBits),
    .vectorBase    (vectorBase),
    .INTA_n        (INTA_n),
    .eoi           (eoi),
    .INT           (a_irq),
    .dataBuffer    (a_dbuf),
    .dataEnable    (a_den),
    .resetIRR      (a_irr),
    .resetIRRValid (a_irr_valid),
    .ISR           (a_isr)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_vector(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed %0h expected none (queue empty)", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      check(tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full two-pulse acknowledge starting from REQ on the AEOI=0 instance.
  task automatic run_seq(input logic [2:0] lvl, input bit spur, input bit eoi_first,
                         input logic [7:0] late, input logic [7:0] exp_isr);
    int n;
    eoi    = eoi_first;
    INTA_n = 1'b0;
    tick();
    eoi = 1'b0;
    if (spur) begin
      check("irr_valid_spur", {7'd0, irr_valid}, 8'd0);
    end else begin
      check("irr_valid", {7'd0, irr_valid}, 8'd1);
      check("irr_level", {5'd0, irr}, {5'd0, lvl});
      risedBits[lvl] = 1'b0;
    end
    check("isr_ack1", isr, exp_isr);
    check("int_ack1", {7'd0, irq}, 8'd1);
    check("den_ack1", {7'd0, den}, 8'd0);
    check("dbuf_ack1", dbuf, 8'd0);
    risedBits = risedBits | late;
    tick();
    check("irr_valid_pulse", {7'd0, irr_valid}, 8'd0);
    INTA_n = 1'b1;
    tick();
    check("den_wait2", {7'd0, den}, 8'd0);
    check("int_wait2", {7'd0, irq}, 8'd1);
    tick();
    exp_q.push_back({vectorBase, lvl});
    INTA_n = 1'b0;
    tick();
    n = 0;
    while (!den && n < 3) begin
      tick();
      n++;
    end
    check("den_ack2", {7'd0, den}, 8'd1);
    check_vector("vector", dbuf);
    INTA_n = 1'b1;
    tick();
    check("int_done", {7'd0, irq}, 8'd0);
    check("den_done", {7'd0, den}, 8'd0);
    check("dbuf_done", dbuf, 8'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    risedBits  = 8'h00;
    vectorBase = 5'b01000;
    INTA_n     = 1'b1;
    eoi        = 1'b0;
    repeat (2) tick();

    // reset values
    check("rst_int", {7'd0, irq}, 8'd0);
    check("rst_den", {7'd0, den}, 8'd0);
    check("rst_dbuf", dbuf, 8'd0);
    check("rst_irr", {5'd0, irr}, 8'd0);
    check("rst_irr_valid", {7'd0, irr_valid}, 8'd0);
    check("rst_isr", isr, 8'd0);
    rst_n = 1'b1;
    tick();

    // IR2 and IR5 pending, IR2 wins; vector 0x42
    risedBits = 8'b0010_0100;
    tick();
    check("t1_int", {7'd0, irq}, 8'd1);
    run_seq(3'd2, 1'b0, 1'b0, 8'h00, 8'h04);
    check("t1_isr", isr, 8'h04);
    tick();
    check("t1_ir5_blocked", {7'd0, irq}, 8'd0);

    // EOI releases IR5
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("t2_isr_eoi", isr, 8'h00);
    check("t2_int_eoi", {7'd0, irq}, 8'd0);
    tick();
    check("t2_int", {7'd0, irq}, 8'd1);
    run_seq(3'd5, 1'b0, 1'b0, 8'h00, 8'h20);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("t2_isr_clr", isr, 8'h00);

    // spurious: request withdrawn at the first INTA falling edge
    vectorBase = 5'b10101;
    risedBits  = 8'h10;
    tick();
    check("t3_int", {7'd0, irq}, 8'd1);
    risedBits = 8'h00;
    run_seq(3'd7, 1'b1, 1'b0, 8'h00, 8'h00);
    check("t3_isr", isr, 8'h00);

    // request withdrawn before any INTA
    risedBits = 8'h10;
    tick();
    check("t3b_int_up", {7'd0, irq}, 8'd1);
    risedBits = 8'h00;
    tick();
    check("t3b_int_down", {7'd0, irq}, 8'd0);

    // higher priority IR0 arrives mid-sequence for IR3
    vectorBase = 5'b01000;
    risedBits  = 8'h08;
    tick();
    run_seq(3'd3, 1'b0, 1'b0, 8'h01, 8'h08);
    check("t4_isr", isr, 8'h08);
    tick();
    check("t4_rereq", {7'd0, irq}, 8'd1);
    run_seq(3'd0, 1'b0, 1'b0, 8'h00, 8'h09);
    eoi = 1'b1;
    tick();
    check("t4_eoi1", isr, 8'h08);
    tick();
    check("t4_eoi2", isr, 8'h00);
    tick();
    eoi = 1'b0;
    check("t4_eoi_empty", isr, 8'h00);

    // EOI on the same edge as the first INTA fall
    risedBits = 8'h08;
    tick();
    run_seq(3'd3, 1'b0, 1'b0, 8'h00, 8'h08);
    risedBits = 8'h02;
    tick();
    check("t5_int", {7'd0, irq}, 8'd1);
    run_seq(3'd1, 1'b0, 1'b1, 8'h00, 8'h02);

    // reset during WAIT2
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    risedBits = 8'h02;
    tick();
    INTA_n = 1'b0;
    tick();
    check("t6_isr", isr, 8'h02);
    risedBits = 8'h00;
    INTA_n = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_isr", isr, 8'h00);
    check("t6_rst_int", {7'd0, irq}, 8'd0);
    check("t6_rst_den", {7'd0, den}, 8'd0);
    check("t6_rst_irr_valid", {7'd0, irr_valid}, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      INTA_n = 1'b0;
      tick();
      check("t6_den_lo", {7'd0, den}, 8'd0);
      INTA_n = 1'b1;
      tick();
      check("t6_den_hi", {7'd0, den}, 8'd0);
      check("t6_int", {7'd0, irq}, 8'd0);
      check("t6_isr_post", isr, 8'h00);
    end

    // AEOI instance: IR3 in service only between the pulses
    risedBits = 8'h08;
    tick();
    check("t7_int", {7'd0, a_irq}, 8'd1);
    INTA_n = 1'b0;
    tick();
    check("t7_isr_set", a_isr, 8'h08);
    check("t7_irr", {5'd0, a_irr}, 8'd3);
    risedBits = 8'h00;
    INTA_n = 1'b1;
    tick();
    tick();
    exp_q.push_back({vectorBase, 3'd3});
    INTA_n = 1'b0;
    tick();
    check("t7_den", {7'd0, a_den}, 8'd1);
    check_vector("t7_vector", a_dbuf);
    INTA_n = 1'b1;
    tick();
    check("t7_isr_clr", a_isr, 8'h00);
    check("t7_main_isr", isr, 8'h08);
    check("t7_int_done", {7'd0, a_irq}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
